// File: rtl/cva5_config.sv
// Shared configuration for the instruction-invalidation broadcast queue.
// Holds the upper bound on consumer count and the default line-address type.
package cva5_config;

  // Upper bound on independent invalidation consumers; also the width of the
  // CSR status half-word that reports per-queue pending state.
  localparam int MAX_INSTR_INV_QUEUES = 16;

  // Default number of byte-offset bits below the line address.
  localparam int INSTR_INV_LINE_SHIFT = 4;

  // Line address as carried through the queue at the default shift.
  typedef logic [31-INSTR_INV_LINE_SHIFT:0] instr_inv_line_t;

endpackage

// File: rtl/instr_inv_queue_bcast_reader.sv
// inv_queue_reader: one consumer's view of the shared invalidation array.
// Owns the read pointer, derives occupancy from the shared write pointer,
// and qualifies the consumer's ack into a pop.
module inv_queue_reader
  import cva5_config::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ack,
  input  logic [PW-1:0] wptr,
  output logic          valid,
  output logic          full,
  output logic          last,
  output logic          pop,
  output logic [AW-1:0] rd_idx
);

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count  = wptr - rptr_q;
  assign valid  = (count != '0);
  assign full   = (count == PW'(DEPTH));
  assign last   = (count == PW'(1));
  assign pop    = ack && valid && !flush;
  assign rd_idx = rptr_q[AW-1:0];

  // Flush snaps this reader to the writer; otherwise advance on a real pop.
  always_comb begin
    rptr_d = rptr_q;
    if (flush)    rptr_d = wptr;
    else if (pop) rptr_d = rptr_q + PW'(1);
  end

  // Read pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rptr_q <= '0;
    else      rptr_q <= rptr_d;
  end

endmodule

// File: rtl/instr_inv_queue_bcast.sv
// instr_inv_queue_bcast: committed-store line invalidations broadcast to
// NUM_QUEUES independent consumers through one shared DEPTH-entry array.
// Each consumer keeps its own read pointer; a slot is reusable only once the
// slowest consumer has passed it, which the per-queue full check enforces.
// Optional feature: define INSTR_INV_QUEUE_COALESCE_EN to drop a push whose
// line repeats the newest entry while every consumer still holds it unread.
module instr_inv_queue_bcast
  import cva5_config::*;
#(
  parameter int NUM_QUEUES = 2,
  parameter int DEPTH      = 4,
  parameter int LINE_SHIFT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inv_valid,
  input  logic [31:0]                        inv_addr,
  output logic                               inv_ready,
  input  logic                               flush,
  output logic [NUM_QUEUES-1:0]              q_valid,
  output logic [NUM_QUEUES*(32-LINE_SHIFT)-1:0] q_line,
  input  logic [NUM_QUEUES-1:0]              q_ack,
  output logic [MAX_INSTR_INV_QUEUES-1:0]    status,
  output logic                               all_empty
);

  localparam int LW = 32 - LINE_SHIFT;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [LW-1:0]                  mem_q [DEPTH];
  logic [PW-1:0]                  wptr_q, wptr_d;
  logic [LW-1:0]                  line_in;
  logic                           push_acc;
  logic                           wr_en;
  logic [NUM_QUEUES-1:0]          full;
  logic [NUM_QUEUES-1:0]          last;
  logic [NUM_QUEUES-1:0]          pop;
  logic [NUM_QUEUES-1:0][AW-1:0]  rd_idx;

  assign line_in = inv_addr[31:LINE_SHIFT];

  // Byte-offset bits never reach the array.
  if (LINE_SHIFT > 0) begin : g_offs
    logic unused_offs;
    assign unused_offs = ^inv_addr[LINE_SHIFT-1:0];
  end

  // Readiness uses pre-pop occupancy, so a full queue popping this cycle
  // still blocks the push; flush also blocks it.
  assign inv_ready = !flush && !(|full);
  assign push_acc  = inv_valid && inv_ready;

`ifdef INSTR_INV_QUEUE_COALESCE_EN
  logic [LW-1:0] last_line_q, last_line_d;
  logic          last_vld_q, last_vld_d;
  logic          coal_hit;
  logic          pop_newest;

  // A repeat of the newest line is redundant only while no consumer has
  // consumed that newest entry yet.
  assign coal_hit   = last_vld_q && (line_in == last_line_q) && (&q_valid);
  assign pop_newest = |(pop & last);
  assign wr_en      = push_acc && !coal_hit;

  // Track the newest written line and whether it is still unread everywhere.
  always_comb begin
    last_line_d = last_line_q;
    last_vld_d  = last_vld_q;
    if (flush) begin
      last_vld_d = 1'b0;
    end else if (wr_en) begin
      last_line_d = line_in;
      last_vld_d  = 1'b1;
    end else if (pop_newest) begin
      last_vld_d = 1'b0;
    end
  end

  // Coalesce state register; the line itself needs no reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vld_q  <= 1'b0;
      last_line_q <= '0;
    end else begin
      last_vld_q  <= last_vld_d;
      last_line_q <= last_line_d;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{last, pop};
  assign wr_en     = push_acc;
`endif

  // Write pointer advances only when an entry is actually stored.
  always_comb begin
    wptr_d = wptr_q;
    if (wr_en) wptr_d = wptr_q + PW'(1);
  end

  // Write pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wptr_q <= '0;
    else      wptr_q <= wptr_d;
  end

  // Entry storage, not reset; contents are only visible behind valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= line_in;
  end

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_rd
    inv_queue_reader #(.DEPTH(DEPTH)) u_rd (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .ack    (q_ack[i]),
      .wptr   (wptr_q),
      .valid  (q_valid[i]),
      .full   (full[i]),
      .last   (last[i]),
      .pop    (pop[i]),
      .rd_idx (rd_idx[i])
    );
    assign q_line[i*LW +: LW] = mem_q[rd_idx[i]];
  end

  // CSR view: one pending bit per implemented queue, upper bits zero.
  always_comb begin
    status                 = '0;
    status[NUM_QUEUES-1:0] = q_valid;
  end

  assign all_empty = ~(|q_valid);

endmodule

// File: tb/tb_instr_inv_queue_bcast.sv
// Bench for instr_inv_queue_bcast (defaults: 2 queues, depth 4, shift 4).
// Reference model keeps one FIFO of line addresses per consumer.
module tb_instr_inv_queue_bcast;
  localparam int NQ = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv_valid;
  logic [31:0] inv_addr;
  logic        inv_ready;
  logic        flush;
  logic [NQ-1:0]    q_valid;
  logic [NQ*28-1:0] q_line;
  logic [NQ-1:0]    q_ack;
  logic [15:0] status;
  logic        all_empty;

  instr_inv_queue_bcast #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .LINE_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .inv_valid(inv_valid), .inv_addr(inv_addr),
    .inv_ready(inv_ready), .flush(flush), .q_valid(q_valid), .q_line(q_line),
    .q_ack(q_ack), .status(status), .all_empty(all_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [27:0] mq [NQ][$];
  logic [27:0] last_ln;
  logic        last_flag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    last_flag = 1'b0;
  endtask

  // Compare every output against the model's current queues.
  task automatic compare();
    logic        rdy;
    logic [NQ-1:0] v;
    rdy = !flush;
    v = '0;
    for (int i = 0; i < NQ; i++) begin
      if (mq[i].size() >= DEPTH) rdy = 1'b0;
      v[i] = (mq[i].size() > 0);
    end
    chk("inv_ready", 64'(inv_ready), 64'(rdy));
    chk("q_valid", 64'(q_valid), 64'(v));
    for (int i = 0; i < NQ; i++)
      if (v[i]) chk("q_line", 64'(q_line[i*28 +: 28]), 64'(mq[i][0]));
    chk("status", 64'(status), 64'(v));
    chk("all_empty", 64'(all_empty), 64'(v == '0));
  endtask

  // Apply the rules to the inputs seen at a clock edge.
  task automatic model_edge();
    logic rdy, hit, pn;
    logic [27:0] ln;
    if (flush) begin
      model_clear();
      return;
    end
    rdy = 1'b1;
    for (int i = 0; i < NQ; i++) if (mq[i].size() >= DEPTH) rdy = 1'b0;
    ln  = inv_addr[31:4];
    hit = 1'b0;
`ifdef INSTR_INV_QUEUE_COALESCE_EN
    hit = last_flag && (ln == last_ln);
    for (int i = 0; i < NQ; i++) if (mq[i].size() == 0) hit = 1'b0;
`endif
    pn = 1'b0;
    for (int i = 0; i < NQ; i++)
      if (q_ack[i] && mq[i].size() > 0) begin
        if (mq[i].size() == 1) pn = 1'b1;
        void'(mq[i].pop_front());
      end
    if (inv_valid && rdy && !hit) begin
      for (int i = 0; i < NQ; i++) mq[i].push_back(ln);
      last_ln = ln;
      last_flag = 1'b1;
    end else if (pn) begin
      last_flag = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic f, input logic [NQ-1:0] ack);
    inv_valid = v; inv_addr = a; flush = f; q_ack = ack;
  endtask

  // One clock: settle, compare, take the edge, update model.
  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, '0);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_ready", 64'(inv_ready), 64'(!flush));
    chk("rst_qvalid", 64'(q_valid), 64'h0);
    chk("rst_status", 64'(status), 64'h0);
    chk("rst_empty", 64'(all_empty), 64'h1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    #3;
    do_reset();

    // Two pushes appear the cycle after their edges.
    drive(1'b1, 32'h8000_0010, 1'b0, '0); cycle();
    drive(1'b1, 32'h8000_0020, 1'b0, '0); cycle();
    idle(); #1;
    chk("d033_qvalid", 64'(q_valid), 64'h3);
    chk("d033_line0", 64'(q_line[27:0]), 64'h800_0001);
    chk("d033_status", 64'(status), 64'h3);
    chk("d033_empty", 64'(all_empty), 64'h0);
    cycle();

    // Queue 1 stalls: fill, drain queue 0, stay blocked until queue 1 pops.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h8000_0100 + 32'(k) * 32'h10, 1'b0, '0); cycle();
    end
    #1; chk("d034_full", 64'(inv_ready), 64'h0);
    // Pop at full with a push offered: the push is rejected.
    drive(1'b1, 32'h8000_0900, 1'b0, 2'b01); cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h8000_0900, 1'b0, 2'b01); #1;
      chk("d034_block", 64'(inv_ready), 64'h0);
      cycle();
    end
    #1; chk("d034_q0_empty", 64'(q_valid), 64'h2);
    drive(1'b1, 32'h8000_0a00, 1'b0, 2'b10); #1;
    chk("d035_prepop", 64'(inv_ready), 64'h0);
    cycle();
    idle(); #1; chk("d034_unblock", 64'(inv_ready), 64'h1);
    cycle();

    // Flush with push and acks asserted discards everything.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h8000_0200 + 32'(k) * 32'h10, 1'b0, '0); cycle();
    end
    drive(1'b1, 32'h8000_0ff0, 1'b1, 2'b11); cycle();
    idle(); #1;
    chk("d036_qvalid", 64'(q_valid), 64'h0);
    chk("d036_empty", 64'(all_empty), 64'h1);
    drive(1'b1, 32'h8000_0330, 1'b0, '0); cycle();
    idle(); #1;
    chk("d036_after", 64'(q_line[27:0]), 64'h800_0033);
    cycle();

`ifdef INSTR_INV_QUEUE_COALESCE_EN
    do_reset();
    drive(1'b1, 32'h8000_0040, 1'b0, '0); cycle();
    drive(1'b1, 32'h8000_0048, 1'b0, '0); cycle();
    drive(1'b0, 32'h0, 1'b0, 2'b01); cycle();
    idle(); #1; chk("d037_one", 64'(q_valid), 64'h2);
    drive(1'b1, 32'h8000_0044, 1'b0, '0); cycle();
    drive(1'b0, 32'h0, 1'b0, 2'b10); cycle();
    idle(); #1; chk("d037_new", 64'(q_valid), 64'h3);
    cycle();
`endif

    // Reset mid-traffic after five writes, with a push pending.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h8000_0400 + 32'(k) * 32'h10, 1'b0, (k >= 2) ? 2'b11 : 2'b00); cycle();
    end
    drive(1'b1, 32'h8000_0500, 1'b0, '0);
    do_reset();
    chk("d038_ready", 64'(inv_ready), 64'h1);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [NQ-1:0] a;
      a = NQ'($urandom_range(0, 3));
      if ((n / 100) % 3 == 1) a[1] = 1'b0;
      drive($urandom_range(0, 9) < 7,
            32'h8000_0000 + (32'($urandom_range(0, 5)) << 3),
            $urandom_range(0, 39) == 0, a);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
